crc_byte_feeder: RTL

CRC_BYTE_FEEDER -- requirements
Module: crc_byte_feeder

---
 rtl/crc_byte_feeder_pkg.sv | 15 +
 rtl/crc_byte_fifo.sv | 62 ++++++
 rtl/crc_byte_feeder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/crc_byte_feeder_pkg.sv
// Shared types and default sizing for the CRC byte feeder.
// Holds the feeder FSM state encoding.
package crc_byte_feeder_pkg;

  localparam int DEF_DATA_WD      = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_CRC_WAIT_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_CRC
  } feed_state_e;

endpackage

// File: rtl/crc_byte_fifo.sv
// Synchronous show-ahead byte buffer carrying data plus a last flag.
// Head entry is visible on pop_data_o/pop_last_o whenever not empty.
module crc_byte_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          pop_last_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit tells full from empty when indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = mem_q[rd_q[AW-1:0]][DW-1:0];
  assign pop_last_o = mem_q[rd_q[AW-1:0]][DW];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= {push_last_i, push_data_i};
    end
  end

endmodule

// File: rtl/crc_byte_feeder.sv
// Serializes buffered bytes LSB-first into a bit-serial CRC engine
// and waits out the engine's CRC readout before the next frame.
module crc_byte_feeder
  import crc_byte_feeder_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CRC_WAIT_MAX = DEF_CRC_WAIT_MAX
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] IN_DATA,
  input  logic               IN_VALID,
  input  logic               IN_LAST,
  output logic               IN_READY,
  output logic               SER_DATA,
  output logic               SER_ACTIVE,
  input  logic               CRC_VALID,
  output logic               FRAME_DONE,
  output logic               BUSY,
  output logic               ERR_UNDERRUN,
  output logic               ERR_TIMEOUT
);

  localparam int BW = $clog2(DATA_WD);
  localparam int CW = $clog2(DATA_WD + 1);
  localparam int TW = $clog2(CRC_WAIT_MAX + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WD - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(DATA_WD - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(CRC_WAIT_MAX - 1);

  feed_state_e        state_q, state_d;
  logic [DATA_WD-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic               last_q, last_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_act_q, ser_act_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               und_q, und_d;
  logic               to_q, to_d;
  logic [TW-1:0]      wait_q, wait_d;
  logic [CW-1:0]      crc_q, crc_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_WD-1:0] head_data;
  logic               head_last;

  crc_byte_fifo #(
    .DW    (DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .push_i      (IN_VALID && !fifo_full),
    .push_data_i (IN_DATA),
    .push_last_i (IN_LAST),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_data),
    .pop_last_o  (head_last),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign IN_READY     = !fifo_full;
  assign SER_DATA     = ser_data_q;
  assign SER_ACTIVE   = ser_act_q;
  assign FRAME_DONE   = done_q;
  assign BUSY         = busy_q;
  assign ERR_UNDERRUN = und_q;
  assign ERR_TIMEOUT  = to_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    last_d     = last_q;
    ser_data_d = ser_data_q;
    ser_act_d  = ser_act_q;
    done_d     = 1'b0;
    und_d      = und_q;
    to_d       = to_q;
    wait_d     = wait_q;
    crc_d      = crc_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = head_data;
          last_d     = head_last;
          bit_d      = '0;
          ser_data_d = head_data[0];
          ser_act_d  = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // shreg_q[0] always mirrors the bit currently on SER_DATA.
        if (bit_q != BIT_LAST) begin
          bit_d      = bit_q + BW'(1);
          shreg_d    = shreg_q >> 1;
          ser_data_d = shreg_q[1];
        end else if (!last_q && !fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = head_data;
          last_d     = head_last;
          bit_d      = '0;
          ser_data_d = head_data[0];
        end else begin
          und_d      = und_q | !last_q;
          ser_act_d  = 1'b0;
          ser_data_d = 1'b0;
          wait_d     = '0;
          crc_d      = '0;
          state_d    = ST_WAIT_CRC;
        end
      end
      ST_WAIT_CRC: begin
        // crc_q != 0 means CRC_VALID has already risen this frame.
        if (CRC_VALID) begin
          if (crc_q == CRC_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            crc_d = crc_q + CW'(1);
          end
        end else if (crc_q != '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_q == TO_LAST) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      ser_data_q <= 1'b0;
      ser_act_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      und_q      <= 1'b0;
      to_q       <= 1'b0;
      wait_q     <= '0;
      crc_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      ser_data_q <= ser_data_d;
      ser_act_q  <= ser_act_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      und_q      <= und_d;
      to_q       <= to_d;
      wait_q     <= wait_d;
      crc_q      <= crc_d;
    end
  end

endmodule
